// File: rtl/pmp_scan_matcher.sv
// pmp_scan_matcher
//
// Sequential PMP address matcher for the OFF, TOR, NA4 and NAPOT modes.
// It evaluates one PMP entry per clock, starting at entry 0. The scan
// stops at the first entry whose region overlaps the access.
//
// Results:
//   - A full cover reports a hit, with the entry's index and {L,X,W,R}.
//   - A partial overlap reports a fault, with the entry's index.
//   - No overlap at all reports neither a hit nor a fault.
//   - An access that wraps past 2^32, or has an illegal size, faults
//     without scanning.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_addr         byte address of the access
//   req_size         0 byte, 1 half-word, 2 word, 3 illegal
//   pmpaddr          NUM_ENTRIES x 32-bit address registers (bits [33:2])
//   pmpcfg           NUM_ENTRIES x 8-bit config {L,-,-,A[1:0],X,W,R}
//   rsp_valid/ready  response handshake; rsp_* held until accepted
//   rsp_hit          one entry fully covers the access
//   rsp_fault        partial overlap, address wrap or illegal size
//   rsp_idx          deciding entry (0 when nothing decided)
//   rsp_perm         {L,X,W,R} of the hitting entry (0 without a hit)

module pmp_scan_matcher #(
   parameter int NUM_ENTRIES = 16,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   input  logic [1:0]               req_size,
   input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
   input  logic [8*NUM_ENTRIES-1:0]  pmpcfg,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_hit,
   output logic                     rsp_fault,
   output logic [IDX_W-1:0]         rsp_idx,
   output logic [3:0]               rsp_perm
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      hi_q, hi_d;
   logic             hit_q, hit_d;
   logic             fault_q, fault_d;
   logic [IDX_W-1:0] ridx_q, ridx_d;
   logic [3:0]       perm_q, perm_d;

   // Request span, computed one bit wider so that a carry out of bit 31
   // flags an access that wraps past the top of the address space.
   logic [32:0] span_hi;
   logic        size_illegal;

   assign span_hi      = {1'b0, req_addr} + ((33'd1 << req_size) - 33'd1);
   assign size_illegal = (req_size == 2'b11);

   // Entry currently under evaluation.
   logic [31:0] cur_addr;
   logic [31:0] prev_addr;
   logic [7:0]  cur_cfg;
   logic [1:0]  unused_cfg_bits;

   assign cur_addr        = pmpaddr[{idx_q, 5'b0} +: 32];
   assign prev_addr       = (idx_q == '0) ? 32'd0 : pmpaddr[{idx_q - IDX_W'(1), 5'b0} +: 32];
   assign cur_cfg         = pmpcfg[{idx_q, 3'b0} +: 8];
   assign unused_cfg_bits = cur_cfg[6:5];

   // Region bounds of the current entry, as 34-bit byte addresses.
   logic [33:0] reg_base;
   logic [33:0] reg_top;
   logic        reg_en;
   logic [31:0] napot_mask;

   // The XOR of a value with its successor sets exactly the trailing ones
   // plus the first zero above them. That is the word-granular size mask
   // of a NAPOT region. All-ones wraps to a full mask, which is the whole
   // address space.
   assign napot_mask = cur_addr ^ (cur_addr + 32'd1);

   always_comb begin
      reg_base = '0;
      reg_top  = '0;
      reg_en   = 1'b0;
      unique case (cur_cfg[4:3])
         2'd1: begin
            reg_base = {prev_addr, 2'b00};
            reg_top  = {cur_addr, 2'b00} - 34'd1;
            // A zero top address would wrap to all ones; treat it as empty.
            reg_en   = (cur_addr != 32'd0) && (reg_base <= reg_top);
         end
         2'd2: begin
            reg_base = {cur_addr, 2'b00};
            reg_top  = {cur_addr, 2'b11};
            reg_en   = 1'b1;
         end
         2'd3: begin
            reg_base = {cur_addr & ~napot_mask, 2'b00};
            reg_top  = {cur_addr | napot_mask, 2'b11};
            reg_en   = 1'b1;
         end
         default: begin
            reg_en   = 1'b0;
         end
      endcase
   end

   logic [33:0] lo34;
   logic [33:0] hi34;
   logic        full_match;
   logic        overlap;

   assign lo34       = {2'b00, lo_q};
   assign hi34       = {2'b00, hi_q};
   assign full_match = reg_en && (reg_base <= lo34) && (hi34 <= reg_top);
   assign overlap    = reg_en && (lo34 <= reg_top) && (hi34 >= reg_base);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      hit_d   = hit_q;
      fault_d = fault_q;
      ridx_d  = ridx_q;
      perm_d  = perm_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               lo_d  = req_addr;
               hi_d  = span_hi[31:0];
               idx_d = '0;
               if (span_hi[32] || size_illegal) begin
                  state_d = RESP;
                  hit_d   = 1'b0;
                  fault_d = 1'b1;
                  ridx_d  = '0;
                  perm_d  = '0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (full_match) begin
               state_d = RESP;
               hit_d   = 1'b1;
               fault_d = 1'b0;
               ridx_d  = idx_q;
               perm_d  = {cur_cfg[7], cur_cfg[2:0]};
            end else if (overlap) begin
               state_d = RESP;
               hit_d   = 1'b0;
               fault_d = 1'b1;
               ridx_d  = idx_q;
               perm_d  = '0;
            end else if (idx_q == LAST_IDX) begin
               state_d = RESP;
               hit_d   = 1'b0;
               fault_d = 1'b0;
               ridx_d  = '0;
               perm_d  = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               idx_d   = '0;
               hit_d   = 1'b0;
               fault_d = 1'b0;
               ridx_d  = '0;
               perm_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         hit_q   <= 1'b0;
         fault_q <= 1'b0;
         ridx_q  <= '0;
         perm_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         hit_q   <= hit_d;
         fault_q <= fault_d;
         ridx_q  <= ridx_d;
         perm_q  <= perm_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_hit   = hit_q;
   assign rsp_fault = fault_q;
   assign rsp_idx   = ridx_q;
   assign rsp_perm  = perm_q;

endmodule
